// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: state codes, select codes,
// the control bundle layout and the legal-opcode list.
package control_unit_pkg;

    // Execute states reuse opcode[6:2] so DISPATCH can load the opcode directly.
    typedef enum logic [4:0] {
        S_LOAD     = 5'b00000,
        S_LOAD_W   = 5'b00001,
        S_LOAD_1   = 5'b00010,
        S_MISCMEM  = 5'b00011,
        S_OPIMM    = 5'b00100,
        S_AUIPC    = 5'b00101,
        S_STORE    = 5'b01000,
        S_STORE_W  = 5'b01001,
        S_STORE_1  = 5'b01010,
        S_OP       = 5'b01100,
        S_LUI      = 5'b01101,
        S_PROLOGUE = 5'b10000,
        S_DISPATCH = 5'b10001,
        S_BRANCH   = 5'b11000,
        S_JALR     = 5'b11001,
        S_JAL      = 5'b11011,
        S_SYSTEM   = 5'b11100
    } state_t;

    localparam logic       ADDR_ALU = 1'b0;
    localparam logic       ADDR_PC  = 1'b1;
    localparam logic [1:0] RD_ALU   = 2'b00;
    localparam logic [1:0] RD_MEM   = 2'b01;
    localparam logic [1:0] RD_PC4   = 2'b10;
    localparam logic [1:0] ALU1_RS  = 2'b00;
    localparam logic [1:0] ALU1_PC  = 2'b01;
    localparam logic [1:0] ALU1_ZR  = 2'b10;
    localparam logic [1:0] ALU2_RS  = 2'b00;
    localparam logic [1:0] ALU2_IM  = 2'b01;
    localparam logic [1:0] ALU2_IS  = 2'b10;
    localparam logic       PC_PC4   = 1'b0;
    localparam logic       PC_ALU   = 1'b1;

    typedef struct packed {
        logic       write_pc;
        logic       write_ir;
        logic       write_rd;
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic [1:0] rd_sel;
        logic [1:0] alu_insel1;
        logic [1:0] alu_insel2;
        logic       pc_sel;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal(logic [4:0] op);
        case (op)
            S_LOAD, S_STORE, S_OPIMM, S_AUIPC, S_OP, S_LUI,
            S_MISCMEM, S_BRANCH, S_JALR, S_JAL, S_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational decode of the current state (plus a few live inputs) into the
// datapath control bundle; reset forces the whole bundle idle.
module control_decode
    import control_unit_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic       halt_req,
    input  logic       mem_complete,
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_cond,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state)
                S_PROLOGUE: begin
                    if (halt_req) begin
                        ctrl.halted = 1'b1;
                    end else begin
                        ctrl.mem_read = 1'b1;
                        ctrl.addr_sel = ADDR_PC;
                        ctrl.write_ir = mem_complete;
                    end
                end
                S_DISPATCH: ctrl.illegal = !is_legal(opcode);
                S_LUI: begin
                    ctrl.alu_insel1 = ALU1_ZR;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.rd_sel     = RD_ALU;
                    ctrl.write_rd   = 1'b1;
                    ctrl.write_pc   = 1'b1;
                end
                S_AUIPC: begin
                    ctrl.alu_insel1 = ALU1_PC;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.rd_sel     = RD_ALU;
                    ctrl.write_rd   = 1'b1;
                    ctrl.write_pc   = 1'b1;
                end
                S_JAL, S_JALR: begin
                    ctrl.alu_insel1 = (state == S_JAL) ? ALU1_PC : ALU1_RS;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.rd_sel     = RD_PC4;
                    ctrl.write_rd   = 1'b1;
                    ctrl.write_pc   = 1'b1;
                    ctrl.pc_sel     = PC_ALU;
                end
                S_BRANCH: begin
                    ctrl.alu_insel1 = ALU1_PC;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.write_pc   = 1'b1;
                    ctrl.pc_sel     = branch_cond ? PC_ALU : PC_PC4;
                end
                S_OPIMM: begin
                    // Shift-immediates (SLLI/SRLI/SRAI) take the shamt operand.
                    ctrl.alu_insel1 = ALU1_RS;
                    ctrl.alu_insel2 = (funct3 == 3'b001 || funct3 == 3'b101) ? ALU2_IS : ALU2_IM;
                    ctrl.rd_sel     = RD_ALU;
                    ctrl.write_rd   = 1'b1;
                    ctrl.write_pc   = 1'b1;
                end
                S_OP: begin
                    ctrl.alu_insel1 = ALU1_RS;
                    ctrl.alu_insel2 = ALU2_RS;
                    ctrl.rd_sel     = RD_ALU;
                    ctrl.write_rd   = 1'b1;
                    ctrl.write_pc   = 1'b1;
                end
                S_MISCMEM, S_SYSTEM: ctrl.write_pc = 1'b1;
                S_LOAD, S_LOAD_W: begin
                    ctrl.alu_insel1 = ALU1_RS;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.addr_sel   = ADDR_ALU;
                    ctrl.mem_read   = 1'b1;
                end
                S_LOAD_1: begin
                    ctrl.rd_sel   = RD_MEM;
                    ctrl.write_rd = 1'b1;
                    ctrl.write_pc = 1'b1;
                end
                S_STORE, S_STORE_W: begin
                    ctrl.alu_insel1 = ALU1_RS;
                    ctrl.alu_insel2 = ALU2_IM;
                    ctrl.addr_sel   = ADDR_ALU;
                    ctrl.mem_write  = 1'b1;
                end
                S_STORE_1: ctrl.write_pc = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I sequencer: fetch into IR, dispatch on opcode[6:2], execute,
// memory and writeback, with an instruction-boundary debug halt in PROLOGUE.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_req,
    input  logic       mem_complete,
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_cond,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       pc_sel,
    output logic       halted,
    output logic       illegal,
    output logic [4:0] state
);

    state_t state_q;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PROLOGUE;
        end else begin
            case (state_q)
                S_PROLOGUE: if (!halt_req && mem_complete) state_q <= S_DISPATCH;
                S_DISPATCH: state_q <= is_legal(opcode) ? state_t'(opcode) : S_PROLOGUE;
                S_LOAD:     state_q <= mem_complete ? S_LOAD_1 : S_LOAD_W;
                S_LOAD_W:   if (mem_complete) state_q <= S_LOAD_1;
                S_STORE:    state_q <= mem_complete ? S_STORE_1 : S_STORE_W;
                S_STORE_W:  if (mem_complete) state_q <= S_STORE_1;
                // Every single-cycle execute state and any stray code return to fetch.
                default:    state_q <= S_PROLOGUE;
            endcase
        end
    end

    control_decode u_decode (
        .rst          (rst),
        .state        (state_q),
        .halt_req     (halt_req),
        .mem_complete (mem_complete),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_cond  (branch_cond),
        .ctrl         (ctrl)
    );

    assign write_pc   = ctrl.write_pc;
    assign write_ir   = ctrl.write_ir;
    assign write_rd   = ctrl.write_rd;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign addr_sel   = ctrl.addr_sel;
    assign rd_sel     = ctrl.rd_sel;
    assign alu_insel1 = ctrl.alu_insel1;
    assign alu_insel2 = ctrl.alu_insel2;
    assign pc_sel     = ctrl.pc_sel;
    assign halted     = ctrl.halted;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle sequencer for the RV32I core. It sits directly upstream of the datapath and drives the control-signal bundle that the datapath consumes.
- Fetches an instruction into IR, dispatches on opcode[6:2], then sequences execute, memory and writeback states.
- Handles the memory handshake via mem_complete and gives the debug unit an instruction-boundary halt point.

Parameters:
- none (encodings live in the shared header)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- halt_req  in  1  debug halt request, sampled only in PROLOGUE
- mem_complete  in  1  one-cycle pulse: current memory request finished; read data captured by the datapath in that cycle
- opcode  in  5  IR[6:2]
- funct3  in  3  IR[14:12]
- branch_cond  in  1  datapath comparator result for the current BRANCH funct3
- write_pc, write_ir, write_rd  out  1 each  register write enables
- mem_read, mem_write  out  1 each  memory request, held until mem_complete
- addr_sel  out  1  ADDR_ALU=0, ADDR_PC=1
- rd_sel  out  2  RD_ALU=00, RD_MEM=01, RD_PC4=10
- alu_insel1  out  2  ALU1_RS=00, ALU1_PC=01, ALU1_ZR=10
- alu_insel2  out  2  ALU2_RS=00, ALU2_IM=01, ALU2_IS=10
- pc_sel  out  1  PC_PC4=0 (incrementer), PC_ALU=1
- halted  out  1  core parked at instruction boundary
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  5  current state, for debug visibility

Behaviour:
- State register
  - 5 bits. Encodings: PROLOGUE=10000, DISPATCH=10001.
  - Execute states equal opcode[6:2]: LOAD=00000, LOAD_W=00001, LOAD_1=00010, STORE=01000, STORE_W=01001, STORE_1=01010, OPIMM=00100, AUIPC=00101, OP=01100, LUI=01101, MISCMEM=00011, BRANCH=11000, JALR=11001, JAL=11011, SYSTEM=11100.
- Outputs
  - All outputs are combinational from state plus the inputs named below.
  - Idle value of every enable, mem_read, mem_write, illegal and halted is 0.
  - Idle value of every select is 0.
- Reset
  - rst high: next state is PROLOGUE, and all outputs are forced to idle that same cycle, so mem_read drops.
  - Reset during LOAD_W or STORE_W abandons the transaction. The memory side must discard it.
- PROLOGUE
  - halt_req=1: halted=1, no request, stay in PROLOGUE.
  - halt_req=0: mem_read=1, addr_sel=PC.
  - On mem_complete: write_ir=1, next is DISPATCH. Otherwise stay.
- DISPATCH
  - Outputs idle.
  - Opcode in the legal set: next = opcode.
  - Otherwise: illegal=1, no PC write, next is PROLOGUE.
- Single-cycle states
  - Each asserts write_pc and returns to PROLOGUE. pc_sel=PC4 unless stated.
  - LUI: alu1=ZR, alu2=IM, rd=ALU, write_rd.
  - AUIPC: alu1=PC, alu2=IM, rd=ALU, write_rd.
  - JAL: alu1=PC, alu2=IM, rd=PC4, write_rd, pc_sel=ALU.
  - JALR: alu1=RS, alu2=IM, rd=PC4, write_rd, pc_sel=ALU.
  - BRANCH: alu1=PC, alu2=IM, pc_sel=branch_cond.
  - OPIMM: alu1=RS, rd=ALU, write_rd. alu2=IS when funct3 is 001 or 101, else IM.
  - OP: alu1=RS, alu2=RS, rd=ALU, write_rd.
  - MISCMEM and SYSTEM: no-op.
- LOAD
  - alu1=RS, alu2=IM, addr_sel=ALU, mem_read=1.
  - mem_complete → LOAD_1, else → LOAD_W.
  - LOAD_W: same outputs; stays until mem_complete, then → LOAD_1.
  - LOAD_1: rd=MEM, write_rd, write_pc → PROLOGUE.
- STORE
  - Same as LOAD with mem_write in place of mem_read. STORE_1 asserts write_pc only.
- Handshake and sampling rules
  - mem_complete is ignored in states that issue no request.
  - mem_read and mem_write are never both 1.
  - halt_req is ignored outside PROLOGUE, so instructions are atomic.
  - Minimum latency with zero-wait memory: ALU or branch instruction 3 cycles, load or store 4 cycles.

Decomposition:
- Shared header control_signals.svh holds:
  - all select codes, including the new RD_PC4 and PC_PC4/PC_ALU;
  - the state encodings;
  - the legal-opcode list.
- Sub-module control_decode: purely combinational state/funct3/branch_cond → output-bundle decode. Keeps the FSM (next-state logic) separate.

Test Plan:
- Reset, then release with halt_req=0 → state=10000, mem_read=1, addr_sel=1 on the first cycle; all other outputs 0.
- Fetch an OP instruction (opcode 01100) with mem_complete on cycle 2 → write_ir=1 that cycle; DISPATCH; then OP with write_rd=1, write_pc=1, alu_insel2=00; back to PROLOGUE.
- LOAD with mem_complete after 3 wait cycles → LOAD, LOAD_W×3, LOAD_1. mem_read=1 throughout the wait; rd_sel=01 and write_rd=1 only in LOAD_1.
- BRANCH with branch_cond=1, then with 0 → pc_sel=1, then 0; write_pc=1 and write_rd=0 both times.
- Opcode 11111 → illegal pulses for exactly 1 cycle in DISPATCH; write_pc=0; next state is PROLOGUE.
- halt_req=1 raised mid-STORE_W, plus rst during LOAD_W:
  - halt: the store completes, then halted=1 in PROLOGUE with no mem_read.
  - reset: mem_read=0 in the reset cycle, then the state is 10000.
